// File: rtl/pwm_pkg.sv
// Shared types and helpers for the LED PWM driver.
package pwm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  localparam int unsigned DutyMaxDefault = 10;

  function automatic int unsigned clamp_duty(input int unsigned duty,
                                             input int unsigned max_duty);
    return (duty > max_duty) ? max_duty : duty;
  endfunction

endpackage

// File: rtl/pwm_led_driver_channel.sv
// One phase-offset PWM output bit, registered one clk after slot/duty.
module pwm_channel #(
  parameter int unsigned DUTY_W   = 4,
  parameter int unsigned DUTY_MAX = 10,
  parameter int unsigned SLOT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SLOT_W-1:0] slot_i,
  input  logic [SLOT_W-1:0] offset_i,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic              run_i,
  input  logic              ch_en_i,
  output logic              pwm_o
);

  localparam logic [SLOT_W-1:0] DutyMaxS = SLOT_W'(DUTY_MAX);

  logic [SLOT_W-1:0] rel;
  logic [DUTY_W-1:0] rel_w;
  logic              pwm_d, pwm_q;

  always_comb begin
    // Wraparound subtraction; truncation keeps it correct when DUTY_MAX is a power of two.
    if (slot_i >= offset_i) begin
      rel = slot_i - offset_i;
    end else begin
      rel = slot_i + DutyMaxS - offset_i;
    end
    rel_w = DUTY_W'(rel);
    pwm_d = ch_en_i && run_i && (rel_w < duty_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_led_driver.sv
// Phase-staggered PWM LED driver: prescaler, slot counter, run/drain FSM and duty capture.
module pwm_led_driver
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DUTY_W     = 4,
  parameter int unsigned DUTY_MAX   = DutyMaxDefault,
  parameter int unsigned PRESCALE   = 2,
  parameter int unsigned PHASE_STEP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pwm,
  output logic              period_start,
  output logic              busy
);

  localparam int unsigned SlotW = (DUTY_MAX > 1) ? $clog2(DUTY_MAX) : 1;
  localparam int unsigned PreW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_e            state_d, state_q;
  logic [PreW-1:0]   pre_cnt_d, pre_cnt_q, pre_next;
  logic [SlotW-1:0]  slot_d, slot_q, slot_next;
  logic [DUTY_W-1:0] duty_sh_d, duty_sh_q;
  logic              period_start_d, period_start_q;
  logic              tick, period_end, boundary, run;

  assign tick       = (pre_cnt_q == PreW'(PRESCALE - 1));
  assign period_end = tick && (slot_q == SlotW'(DUTY_MAX - 1));
  assign pre_next   = tick ? '0 : pre_cnt_q + 1'b1;
  assign slot_next  = !tick ? slot_q : (period_end ? '0 : slot_q + 1'b1);

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    slot_d    = slot_q;
    boundary  = 1'b0;
    unique case (state_q)
      StIdle: begin
        pre_cnt_d = '0;
        slot_d    = '0;
        if (en) begin
          state_d  = StRun;
          boundary = 1'b1;
        end
      end
      StRun: begin
        pre_cnt_d = pre_next;
        slot_d    = slot_next;
        if (!en) begin
          state_d = StDrain;
        end else begin
          boundary = period_end;
        end
      end
      StDrain: begin
        pre_cnt_d = pre_next;
        slot_d    = slot_next;
        if (en) begin
          // Resume without touching the counters; a wrap on this cycle still starts a period.
          state_d  = StRun;
          boundary = period_end;
        end else if (period_end) begin
          state_d   = StIdle;
          pre_cnt_d = '0;
          slot_d    = '0;
        end
      end
      default: begin
        state_d   = StIdle;
        pre_cnt_d = '0;
        slot_d    = '0;
      end
    endcase
    duty_sh_d      = boundary ? DUTY_W'(clamp_duty(32'(duty_in), DUTY_MAX)) : duty_sh_q;
    period_start_d = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      pre_cnt_q      <= '0;
      slot_q         <= '0;
      duty_sh_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      slot_q         <= slot_d;
      duty_sh_q      <= duty_sh_d;
      period_start_q <= period_start_d;
    end
  end

  // Gating on both sides keeps pwm low on entry to IDLE and before the first duty capture.
  assign run          = (state_q != StIdle) && (state_d != StIdle);
  assign busy         = (state_q != StIdle);
  assign period_start = period_start_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int unsigned Offset = (i * PHASE_STEP) % DUTY_MAX;

    pwm_channel #(
      .DUTY_W  (DUTY_W),
      .DUTY_MAX(DUTY_MAX),
      .SLOT_W  (SlotW)
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .slot_i  (slot_q),
      .offset_i(SlotW'(Offset)),
      .duty_i  (duty_sh_q),
      .run_i   (run),
      .ch_en_i (ch_en[i]),
      .pwm_o   (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_led_driver.sv
// Directed bench for pwm_led_driver: one default instance and one with PHASE_STEP=3.
module tb_pwm_led_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] duty_in;
  logic [3:0] ch_en;
  logic [3:0] pwm, pwm_ph;
  logic       ps, ps_ph;
  logic       busy, busy_ph;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_led_driver #(
    .NUM_CH(4), .DUTY_W(4), .DUTY_MAX(10), .PRESCALE(2), .PHASE_STEP(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .duty_in(duty_in), .ch_en(ch_en),
    .pwm(pwm), .period_start(ps), .busy(busy)
  );

  pwm_led_driver #(
    .NUM_CH(4), .DUTY_W(4), .DUTY_MAX(10), .PRESCALE(2), .PHASE_STEP(3)
  ) dut_ph (
    .clk(clk), .rst(rst), .en(en), .duty_in(duty_in), .ch_en(ch_en),
    .pwm(pwm_ph), .period_start(ps_ph), .busy(busy_ph)
  );

  // Pattern bit k is the sample k+1 clocks after a period_start cycle.
  typedef struct packed {
    logic [3:0]       duty;
    logic [3:0]       ch_en;
    logic [19:0]      exp0;
    logic [3:0][19:0] exp_ph;
  } vec_t;

  vec_t vecs[6];

  logic [19:0]      cap0, cap_ps, cap_busy;
  logic [3:0][19:0] cap_ph;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ps(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps && n < 60);
    checks++;
    if (!ps) begin
      errors++;
      $display("FAIL %s: period_start not seen within 60 clk, got 0, expected 1", name);
    end
  endtask

  task automatic capture(input int mid_k, input logic [3:0] mid_duty);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cap0[k]     = pwm[0];
      cap_ps[k]   = ps;
      cap_busy[k] = busy;
      for (int c = 0; c < 4; c++) cap_ph[c][k] = pwm_ph[c];
      if (k == mid_k) duty_in = mid_duty;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b_pat, p_pat, w_pat;
    logic [11:0] b12, p12, w12;

    vecs[0] = '{duty: 4'd3,  ch_en: 4'b0001, exp0: 20'h0003F,
                exp_ph: {20'h0, 20'h0, 20'h0, 20'h0003F}};
    vecs[1] = '{duty: 4'd7,  ch_en: 4'b0001, exp0: 20'h03FFF,
                exp_ph: {20'h0, 20'h0, 20'h0, 20'h03FFF}};
    vecs[2] = '{duty: 4'd15, ch_en: 4'b1001, exp0: 20'hFFFFF,
                exp_ph: {20'hFFFFF, 20'h0, 20'h0, 20'hFFFFF}};
    vecs[3] = '{duty: 4'd0,  ch_en: 4'b1111, exp0: 20'h00000,
                exp_ph: {20'h0, 20'h0, 20'h0, 20'h0}};
    vecs[4] = '{duty: 4'd2,  ch_en: 4'b1111, exp0: 20'h0000F,
                exp_ph: {20'hC0003, 20'h0F000, 20'h003C0, 20'h0000F}};
    vecs[5] = '{duty: 4'd5,  ch_en: 4'b1000, exp0: 20'h00000,
                exp_ph: {20'hC00FF, 20'h0, 20'h0, 20'h0}};

    rst = 1'b1; en = 1'b0; duty_in = '0; ch_en = '0;
    #2;
    check("reset pwm", {28'h0, pwm}, 32'h0);
    check("reset pwm_ph", {28'h0, pwm_ph}, 32'h0);
    check("reset period_start", {31'h0, ps}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    en = 1'b1; duty_in = 4'd5; ch_en = 4'hF;
    #21;
    check("reset overrides en busy", {31'h0, busy}, 32'h0);
    check("reset overrides en pwm", {28'h0, pwm}, 32'h0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle with en=0 busy", {31'h0, busy}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      duty_in = vecs[i].duty;
      ch_en   = vecs[i].ch_en;
      en      = 1'b1;
      wait_ps($sformatf("vec%0d start", i));
      capture(-1, 4'd0);
      check($sformatf("vec%0d pwm0", i), {12'h0, cap0}, {12'h0, vecs[i].exp0});
      for (int c = 0; c < 4; c++)
        check($sformatf("vec%0d pwm_ph%0d", i, c), {12'h0, cap_ph[c]},
              {12'h0, vecs[i].exp_ph[c]});
      check($sformatf("vec%0d period_start", i), {12'h0, cap_ps}, 32'h80000);
      check($sformatf("vec%0d busy", i), {12'h0, cap_busy}, 32'hFFFFF);
    end

    // Mid-period duty change must wait for the next boundary.
    duty_in = 4'd3; ch_en = 4'b0001;
    wait_ps("mid start");
    capture(5, 4'd7);
    check("mid change current period", {12'h0, cap0}, 32'h0003F);
    check("mid change period_start", {12'h0, cap_ps}, 32'h80000);
    capture(-1, 4'd0);
    check("mid change next period", {12'h0, cap0}, 32'h03FFF);

    // Drain: en dropped at slot 4, run to the end of slot 9, then idle.
    duty_in = 4'd15;
    wait_ps("drain start");
    repeat (8) @(negedge clk);
    en = 1'b0;
    for (int n = 9; n <= 24; n++) begin
      @(negedge clk);
      b_pat[n-9] = busy;
      p_pat[n-9] = ps;
      w_pat[n-9] = pwm[0];
    end
    check("drain busy", {16'h0, b_pat}, 32'h07FF);
    check("drain period_start", {16'h0, p_pat}, 32'h0000);
    check("drain pwm", {16'h0, w_pat}, 32'h07FF);

    en = 1'b1;
    @(negedge clk);
    check("restart period_start latency", {31'h0, ps}, 32'h1);
    check("restart busy", {31'h0, busy}, 32'h1);

    // Re-raise en during drain: counters keep going, next boundary on schedule.
    repeat (8) @(negedge clk);
    en = 1'b0;
    for (int n = 9; n <= 20; n++) begin
      @(negedge clk);
      b12[n-9] = busy;
      p12[n-9] = ps;
      w12[n-9] = pwm[0];
      if (n == 12) en = 1'b1;
    end
    check("reraise busy", {20'h0, b12}, 32'hFFF);
    check("reraise period_start", {20'h0, p12}, 32'h800);
    check("reraise pwm", {20'h0, w12}, 32'hFFF);

    // Asynchronous reset mid-period with pwm high.
    repeat (3) @(negedge clk);
    check("pre-reset pwm", {28'h0, pwm}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async reset pwm", {28'h0, pwm}, 32'h0);
    check("async reset pwm_ph", {28'h0, pwm_ph}, 32'h0);
    check("async reset busy", {31'h0, busy}, 32'h0);
    check("async reset period_start", {31'h0, ps}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset period_start", {31'h0, ps}, 32'h1);
    check("post-reset pwm latency", {28'h0, pwm}, 32'h0);
    @(negedge clk);
    check("post-reset pwm high", {28'h0, pwm}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
